mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15: maximum BUSY cycles before watchdog abort.
REQ-002 SHALL have parameter STARVE_LIM, default 4: consecutive data grants tolerated while fetch waits.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 if_req  in  1  fetch request, level, held until if_done.
REQ-006 if_addr  in  16  fetch address.
REQ-007 hlt  in  1  halt; blocks new fetch grants.
REQ-008 dm_rd, dm_wr  in  1 each  data read/write request, level, held until dm_done; never both high.
REQ-009 dm_addr, dm_wdata  in  16 each  data address, store data.
REQ-010 mem_req  out  1  memory transaction start pulse.
REQ-011 mem_wr  out  1  write qualifier.
REQ-012 mem_addr, mem_wdata  out  16 each  latched address/data.
REQ-013 mem_rdata  in  16  memory read data, valid with mem_done.
REQ-014 mem_done  in  1  memory completion, one cycle.
REQ-015 if_done, dm_done  out  1 each  completion strobes; if_rdata, dm_rdata  out  16 each.
REQ-016 if_stall, dm_stall  out  1 each  pipeline stall; err  out  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM IDLE, IF_BUSY, DM_BUSY.
REQ-018 IDLE: data request (dm_rd|dm_wr) -> DM_BUSY; else if_req & ~hlt -> IF_BUSY; else stay.
REQ-019 Priority: data over fetch, except when starve counter = STARVE_LIM and if_req & ~hlt, fetch wins.
REQ-020 Starve counter: +1 per data grant while if_req pending, saturating at STARVE_LIM; cleared on fetch grant or when if_req low.
REQ-021 On grant, mem_addr/mem_wdata/mem_wr SHALL be registered from the winner and held constant throughout BUSY.
REQ-022 mem_req SHALL be high for exactly the first BUSY cycle.
REQ-023 mem_done accepted in any BUSY cycle, including the mem_req cycle; FSM returns to IDLE at the next edge.
REQ-024 if_done = IF_BUSY & mem_done; dm_done = DM_BUSY & mem_done (combinational); if_rdata/dm_rdata = mem_rdata passthrough.
REQ-025 Minimum request-to-done latency 1 cycle; at least one IDLE cycle between transactions.
REQ-026 if_stall = if_req & ~if_done; dm_stall = (dm_rd|dm_wr) & ~dm_done.
REQ-027 mem_done in IDLE SHALL be ignored.
REQ-028 hlt mid-fetch SHALL NOT abort the fetch in progress.

Reset
REQ-029 While rst low: state IDLE, mem_req 0, mem_wr 0, mem_addr/mem_wdata 0, starve counter 0, watchdog 0, err 0.
REQ-030 Reset during BUSY abandons the transaction; a late mem_done after reset release is ignored per REQ-027.

Configuration
REQ-031 Macro MEM_ARB_TIMEOUT_EN defined: watchdog counts BUSY cycles; on reaching TIMEOUT_CYC without mem_done, the requester's done strobe SHALL pulse with rdata 16'hFFFF, err SHALL set, FSM SHALL return to IDLE.
REQ-032 Macro undefined: no watchdog logic; BUSY waits indefinitely; err SHALL be tied 0.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the FSM state enum, TIMEOUT_CYC and STARVE_LIM defaults, and the 16'hFFFF abort value.
REQ-034 Sub-module mem_arb_wdog SHALL implement the watchdog counter (start, clear, expire); instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-035 Fetch only: if_req, if_addr=16'h0040, mem_done 3 cycles after mem_req, mem_rdata=16'hA5A5 -> single mem_req pulse, mem_addr 16'h0040, if_done with if_rdata 16'hA5A5, mem_wr 0.
REQ-036 Simultaneous if_req and dm_wr (dm_addr=16'h0100, dm_wdata=16'h1234) in IDLE -> data granted first, mem_wr 1, mem_wdata 16'h1234; fetch granted after the following IDLE cycle.
REQ-037 Fetch held continuously; 5 back-to-back data requests -> fetch granted after the 4th data grant, before the 5th.
REQ-038 hlt=1 with if_req and no data request -> no mem_req, if_stall 1; dm_rd then arrives -> data served normally.
REQ-039 Reset asserted mid DM_BUSY, mem_done 2 cycles after release -> all outputs zero, no dm_done, FSM IDLE.
REQ-040 With MEM_ARB_TIMEOUT_EN, no mem_done for 15 cycles -> dm_done pulse with dm_rdata 16'hFFFF, err 1 and held until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// default timing limits and the read data returned on a watchdog abort.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CYC_DEF = 15;
  localparam int STARVE_LIM_DEF  = 4;

  localparam logic [15:0] ABORT_RDATA = 16'hFFFF;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog counter for the memory arbiter. Counts cycles while a
// transaction is in flight and flags expiry on the TIMEOUT_CYC-th
// cycle. Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of BUSY cycles already completed, so the
  // current cycle is number cnt+1.
  assign expire = start & (cnt == CW'(TIMEOUT_CYC - 1));

  // Count while a transaction is running; restart whenever it ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || !start) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data normally wins; a starvation counter forces a fetch grant after
// STARVE_LIM consecutive data grants while fetch waits.
// Optional watchdog abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int STARVE_LIM  = STARVE_LIM_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        hlt,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        if_done,
  output logic        dm_done,
  output logic [15:0] if_rdata,
  output logic [15:0] dm_rdata,
  output logic        if_stall,
  output logic        dm_stall,
  output logic        err
);

  localparam int SW = $clog2(STARVE_LIM + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  arb_state_t    state, state_nxt;
  logic          dm_any, if_ok, busy, fin, abort;
  logic          grant_if, grant_dm;
  logic [SW-1:0] starve;

  assign dm_any = dm_rd | dm_wr;
  assign if_ok  = if_req & ~hlt;
  assign busy   = (state != ST_IDLE);
  // A transaction ends on memory completion or on a watchdog abort.
  assign fin    = busy & (mem_done | abort);

`ifdef MEM_ARB_TIMEOUT_EN
  logic expire;
  logic err_q;

  mem_arb_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .start (busy),
    .clear (fin),
    .expire(expire)
  );

  // A real completion in the expiry cycle wins over the abort.
  assign abort = expire & ~mem_done;

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and grant decode; grants are only issued from IDLE, which
  // guarantees an idle cycle between back-to-back transactions.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (if_ok && (starve == STARVE_MAX)) begin
          grant_if  = 1'b1;
          state_nxt = ST_IF_BUSY;
        end else if (dm_any) begin
          grant_dm  = 1'b1;
          state_nxt = ST_DM_BUSY;
        end else if (if_ok) begin
          grant_if  = 1'b1;
          state_nxt = ST_IF_BUSY;
        end
      end
      ST_IF_BUSY, ST_DM_BUSY: begin
        if (mem_done || abort) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's request on grant and hold it for the whole
  // transaction; mem_req marks only the first BUSY cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req <= grant_if | grant_dm;
      if (grant_dm) begin
        mem_wr    <= dm_wr;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grant_if) begin
        mem_wr    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
    end
  end

  // Count data grants that overtook a waiting fetch, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (!if_req || grant_if) begin
      starve <= '0;
    end else if (grant_dm && (starve != STARVE_MAX)) begin
      starve <= starve + 1'b1;
    end
  end

  assign if_done  = (state == ST_IF_BUSY) & (mem_done | abort);
  assign dm_done  = (state == ST_DM_BUSY) & (mem_done | abort);
  assign if_rdata = abort ? ABORT_RDATA : mem_rdata;
  assign dm_rdata = abort ? ABORT_RDATA : mem_rdata;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_any & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TMO  = 15;
  localparam int SLIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        hlt;
  logic        dm_rd, dm_wr;
  logic [15:0] dm_addr, dm_wdata;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;
  logic        if_done, dm_done;
  logic [15:0] if_rdata, dm_rdata;
  logic        if_stall, dm_stall, err;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT_CYC(TMO), .STARVE_LIM(SLIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .hlt(hlt),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .if_done(if_done), .dm_done(dm_done), .if_rdata(if_rdata), .dm_rdata(dm_rdata),
    .if_stall(if_stall), .dm_stall(dm_stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cyc;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    if_req = 1'b0; if_addr = '0; hlt = 1'b0;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_done = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b1;
    next_cyc();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b0;
    if_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h1111; dm_wdata = 16'h2222;
    mem_done = 1'b1;
    mid_cyc();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rst_mem_wr got=%0h exp=0", mem_wr); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
    total++; if (mem_wdata !== 16'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0000", mem_wdata); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h exp=0", err); end
    total++; if (dm_done !== 1'b0 || if_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b%0b exp=00", if_done, dm_done); end
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL rst_if_stall got=%0h exp=1", if_stall); end
    next_cyc();
    idle_inputs();
    rst = 1'b1;
    next_cyc();
    mid_cyc();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_release_req got=%0h exp=0", mem_req); end
    next_cyc();
  endtask

  task automatic test_fetch_only;
    int p;
    p = 0;
    do_reset();
    if_req = 1'b1; if_addr = 16'h0040;
    mid_cyc(); if (mem_req) p++;
    next_cyc();
    mid_cyc(); if (mem_req) p++;
    total++; if (mem_addr !== 16'h0040) begin bad++; $display("FAIL fetch_addr got=%h exp=0040", mem_addr); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL fetch_wr got=%0h exp=0", mem_wr); end
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      mid_cyc(); if (mem_req) p++;
      total++; if (if_done !== 1'b0) begin bad++; $display("FAIL fetch_early_done got=%0h exp=0", if_done); end
    end
    next_cyc();
    mem_done = 1'b1; mem_rdata = 16'hA5A5;
    mid_cyc(); if (mem_req) p++;
    total++; if (if_done !== 1'b1) begin bad++; $display("FAIL fetch_done got=%0h exp=1", if_done); end
    total++; if (if_rdata !== 16'hA5A5) begin bad++; $display("FAIL fetch_rdata got=%h exp=a5a5", if_rdata); end
    total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL fetch_stall_release got=%0h exp=0", if_stall); end
    total++; if (mem_addr !== 16'h0040) begin bad++; $display("FAIL fetch_addr_held got=%h exp=0040", mem_addr); end
    next_cyc();
    mem_done = 1'b0; if_req = 1'b0;
    mid_cyc(); if (mem_req) p++;
    total++; if (if_done !== 1'b0) begin bad++; $display("FAIL fetch_done_after got=%0h exp=0", if_done); end
    next_cyc();
    mid_cyc(); if (mem_req) p++;
    total++; if (p !== 1) begin bad++; $display("FAIL fetch_req_pulses got=%0d exp=1", p); end
    next_cyc();
  endtask

  task automatic test_priority;
    do_reset();
    if_req = 1'b1; if_addr = 16'h0200;
    dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
    next_cyc();
    mem_done = 1'b1; mem_rdata = 16'h0;
    mid_cyc();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL prio_dm_req got=%0h exp=1", mem_req); end
    total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL prio_dm_wr got=%0h exp=1", mem_wr); end
    total++; if (mem_addr !== 16'h0100) begin bad++; $display("FAIL prio_dm_addr got=%h exp=0100", mem_addr); end
    total++; if (mem_wdata !== 16'h1234) begin bad++; $display("FAIL prio_dm_wdata got=%h exp=1234", mem_wdata); end
    total++; if (dm_done !== 1'b1 || if_done !== 1'b0) begin bad++; $display("FAIL prio_dm_done got=if%0b/dm%0b exp=if0/dm1", if_done, dm_done); end
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL prio_if_stall got=%0h exp=1", if_stall); end
    next_cyc();
    mem_done = 1'b0; dm_wr = 1'b0;
    mid_cyc();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL prio_idle_gap got=%0h exp=0", mem_req); end
    next_cyc();
    mem_done = 1'b1; mem_rdata = 16'h7777;
    mid_cyc();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200 || mem_wr !== 1'b0) begin bad++; $display("FAIL prio_if_grant got=req%0b addr=%h wr=%0b exp=req1 addr=0200 wr0", mem_req, mem_addr, mem_wr); end
    total++; if (if_done !== 1'b1 || if_rdata !== 16'h7777) begin bad++; $display("FAIL prio_if_done got=%0b/%h exp=1/7777", if_done, if_rdata); end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_starve;
    string order;
    int dcnt;
    do_reset();
    order = "";
    dcnt = 0;
    if_req = 1'b1; if_addr = 16'h0300;
    dm_rd = 1'b1; dm_addr = 16'h1000;
    for (int c = 0; c < 60 && order.len() < 6; c++) begin
      next_cyc();
      if (dcnt >= 5) dm_rd = 1'b0;
      if (mem_req) begin
        mem_done = 1'b1;
        if (mem_addr == 16'h0300) order = {order, "F"};
        else begin
          order = {order, "D"};
          dcnt++;
          dm_addr = 16'h1000 + 16'(dcnt);
        end
      end else begin
        mem_done = 1'b0;
      end
    end
    total++; if (order != "DDDDFD") begin bad++; $display("FAIL starve_order got=%s exp=DDDDFD", order); end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_halt;
    int p;
    do_reset();
    p = 0;
    hlt = 1'b1; if_req = 1'b1; if_addr = 16'h0055;
    for (int i = 0; i < 4; i++) begin
      mid_cyc(); if (mem_req) p++;
      next_cyc();
    end
    total++; if (p !== 0) begin bad++; $display("FAIL halt_no_req got=%0d exp=0", p); end
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL halt_if_stall got=%0h exp=1", if_stall); end
    dm_rd = 1'b1; dm_addr = 16'h0ABC;
    next_cyc();
    mem_done = 1'b1; mem_rdata = 16'h5A5A;
    mid_cyc();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0ABC || mem_wr !== 1'b0) begin bad++; $display("FAIL halt_dm_grant got=req%0b addr=%h wr=%0b exp=req1 addr=0abc wr0", mem_req, mem_addr, mem_wr); end
    total++; if (dm_done !== 1'b1 || dm_rdata !== 16'h5A5A) begin bad++; $display("FAIL halt_dm_done got=%0b/%h exp=1/5a5a", dm_done, dm_rdata); end
    next_cyc();
    mem_done = 1'b0; dm_rd = 1'b0;
    p = 0;
    for (int i = 0; i < 3; i++) begin
      mid_cyc(); if (mem_req) p++;
      next_cyc();
    end
    total++; if (p !== 0) begin bad++; $display("FAIL halt_after_dm got=%0d exp=0", p); end
    hlt = 1'b0;
    next_cyc();
    hlt = 1'b1;
    mid_cyc();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0055) begin bad++; $display("FAIL halt_fetch_grant got=req%0b addr=%h exp=req1 addr=0055", mem_req, mem_addr); end
    next_cyc();
    mem_done = 1'b1; mem_rdata = 16'h1111;
    mid_cyc();
    total++; if (if_done !== 1'b1 || if_rdata !== 16'h1111) begin bad++; $display("FAIL halt_midfetch_done got=%0b/%h exp=1/1111", if_done, if_rdata); end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_reset_mid_busy;
    do_reset();
    dm_wr = 1'b1; dm_addr = 16'h0F0F; dm_wdata = 16'hCAFE;
    next_cyc();
    mid_cyc();
    total++; if (mem_req !== 1'b1 || mem_wr !== 1'b1) begin bad++; $display("FAIL rmid_start got=req%0b wr%0b exp=req1 wr1", mem_req, mem_wr); end
    next_cyc();
    rst = 1'b0; dm_wr = 1'b0;
    mid_cyc();
    total++; if (mem_req !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin bad++; $display("FAIL rmid_outputs got=req%0b wr%0b addr=%h wdata=%h exp=all zero", mem_req, mem_wr, mem_addr, mem_wdata); end
    next_cyc();
    rst = 1'b1;
    next_cyc();
    next_cyc();
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    mid_cyc();
    total++; if (dm_done !== 1'b0 || if_done !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rmid_late_done got=if%0b dm%0b req%0b exp=000", if_done, dm_done, mem_req); end
    next_cyc();
    mem_done = 1'b0;
    mid_cyc();
    total++; if (mem_req !== 1'b0 || mem_addr !== 16'h0 || err !== 1'b0) begin bad++; $display("FAIL rmid_idle got=req%0b addr=%h err%0b exp=0/0000/0", mem_req, mem_addr, err); end
    next_cyc();
    dm_wr = 1'b1; dm_addr = 16'h2222; dm_wdata = 16'h3333;
    next_cyc();
    mem_done = 1'b1;
    mid_cyc();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h2222 || dm_done !== 1'b1) begin bad++; $display("FAIL rmid_fresh got=req%0b addr=%h done%0b exp=1/2222/1", mem_req, mem_addr, dm_done); end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_timeout;
    int early;
    do_reset();
    early = 0;
    dm_rd = 1'b1; dm_addr = 16'h0777;
    next_cyc();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 1; i <= TMO; i++) begin
      mid_cyc();
      if (i < TMO) begin
        if (dm_done) early++;
      end else begin
        total++; if (dm_done !== 1'b1 || dm_rdata !== 16'hFFFF) begin bad++; $display("FAIL tmo_abort got=%0b/%h exp=1/ffff", dm_done, dm_rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_early got=%0h exp=0", err); end
      end
      next_cyc();
    end
    total++; if (early !== 0) begin bad++; $display("FAIL tmo_early_done got=%0d exp=0", early); end
    dm_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid_cyc();
      total++; if (err !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL tmo_err_sticky got=err%0b req%0b exp=err1 req0", err, mem_req); end
      next_cyc();
    end
    do_reset();
    mid_cyc();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_reset got=%0h exp=0", err); end
    next_cyc();
`else
    for (int i = 1; i <= TMO + 10; i++) begin
      mid_cyc();
      if (dm_done || err || !dm_stall) early++;
      next_cyc();
    end
    total++; if (early !== 0) begin bad++; $display("FAIL notmo_wait got=%0d bad cycles exp=0", early); end
    mem_done = 1'b1; mem_rdata = 16'h4321;
    mid_cyc();
    total++; if (dm_done !== 1'b1 || dm_rdata !== 16'h4321 || err !== 1'b0) begin bad++; $display("FAIL notmo_done got=%0b/%h err%0b exp=1/4321/0", dm_done, dm_rdata, err); end
    next_cyc();
`endif
    idle_inputs();
    next_cyc();
  endtask

  // Reference model: tracks which requester owns the memory, the latched
  // request, whether this is the first cycle, and the starvation count.
  task automatic test_random;
    int owner, starve, lat, g;
    bit first, wr, e_ifd, e_dmd, last_ifd, last_dmd, fok, dany;
    logic [15:0] addr, wdata;
    do_reset();
    owner = 0; starve = 0; lat = 0; first = 0; wr = 0; addr = '0; wdata = '0;
    last_ifd = 0; last_dmd = 0;
    for (int c = 0; c < 400; c++) begin
      if (last_ifd) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = 16'($urandom); end
      if (last_dmd) begin dm_rd = 1'b0; dm_wr = 1'b0; end
      else if (!dm_rd && !dm_wr && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) dm_wr = 1'b1; else dm_rd = 1'b1;
        dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
      end
      hlt = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
      if (owner != 0) begin mem_done = (lat == 0); lat--; end
      else mem_done = ($urandom_range(0, 7) == 0);
      e_ifd = (owner == 1) && mem_done;
      e_dmd = (owner == 2) && mem_done;
      mid_cyc();
      total++; if (mem_req !== first) begin bad++; $display("FAIL rnd_mem_req c=%0d got=%0b exp=%0b", c, mem_req, first); end
      total++; if (mem_addr !== addr || mem_wr !== wr) begin bad++; $display("FAIL rnd_mem_addr c=%0d got=%h/%0b exp=%h/%0b", c, mem_addr, mem_wr, addr, wr); end
      if (wr) begin
        total++; if (mem_wdata !== wdata) begin bad++; $display("FAIL rnd_mem_wdata c=%0d got=%h exp=%h", c, mem_wdata, wdata); end
      end
      total++; if (if_done !== e_ifd || dm_done !== e_dmd) begin bad++; $display("FAIL rnd_done c=%0d got=if%0b dm%0b exp=if%0b dm%0b", c, if_done, dm_done, e_ifd, e_dmd); end
      total++; if (if_stall !== (if_req && !e_ifd) || dm_stall !== ((dm_rd || dm_wr) && !e_dmd)) begin bad++; $display("FAIL rnd_stall c=%0d got=if%0b dm%0b", c, if_stall, dm_stall); end
      if (e_ifd || e_dmd) begin
        total++; if ((e_ifd && if_rdata !== mem_rdata) || (e_dmd && dm_rdata !== mem_rdata)) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h", c, if_rdata, dm_rdata, mem_rdata); end
      end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err c=%0d got=%0b exp=0", c, err); end
      // advance the model to the next edge
      g = 0;
      if (owner != 0) begin
        first = 0;
        if (mem_done) owner = 0;
      end else begin
        fok = if_req && !hlt;
        dany = dm_rd || dm_wr;
        if (fok && starve == SLIM) g = 1;
        else if (dany) g = 2;
        else if (fok) g = 1;
        first = (g != 0);
        if (g == 1) begin owner = 1; addr = if_addr; wr = 0; end
        if (g == 2) begin owner = 2; addr = dm_addr; wr = dm_wr; wdata = dm_wdata; end
        if (g != 0) lat = $urandom_range(0, 4);
      end
      if (!if_req || g == 1) starve = 0;
      else if (g == 2 && starve < SLIM) starve++;
      last_ifd = e_ifd;
      last_dmd = e_dmd;
      next_cyc();
    end
    idle_inputs();
    next_cyc();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_priority();
    test_starve();
    test_halt();
    test_reset_mid_busy();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule
